// File: rtl/keypad_scan4.sv
// 4x4 keypad scanner: walks a one-cold column drive, debounces a pressed row,
// reports the confirmed key code and tracks the hold until a debounced release.
module keypad_scan4 #(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       tick,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam logic [3:0] DB_TICKS = 4'(DEBOUNCE_TICKS);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t     state, state_n;
    logic [1:0] col, col_n;
    logic [1:0] row, row_n;
    logic [3:0] cnt, cnt_n;
    logic [3:0] code_n;
    logic       valid_n;
    logic       held_n;

    logic [3:0] rs_p0;
    logic [3:0] rs;

    // Lowest-indexed low row wins when several rows are pulled at once.
    function automatic logic [1:0] lowest_zero(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] c);
        return ~(4'b0001 << c);
    endfunction

    // Stage p0/p1: two-flop synchronizer for the asynchronous row lines.
    always_ff @(posedge clk) begin
        if (Reset) begin
            rs_p0 <= 4'hF;
            rs    <= 4'hF;
        end else begin
            rs_p0 <= rows;
            rs    <= rs_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state     <= SCAN;
            col       <= 2'd0;
            row       <= 2'd0;
            cnt       <= 4'd0;
            cols      <= 4'b1110;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_n;
            col       <= col_n;
            row       <= row_n;
            cnt       <= cnt_n;
            cols      <= col_drive(col_n);
            key_code  <= code_n;
            key_valid <= valid_n;
            key_held  <= held_n;
        end
    end

    always_comb begin
        state_n = state;
        col_n   = col;
        row_n   = row;
        cnt_n   = cnt;
        code_n  = key_code;
        valid_n = 1'b0;
        held_n  = key_held;

        if (tick) begin
            case (state)
                SCAN: begin
                    if (rs == 4'hF) begin
                        col_n = col + 2'd1;
                    end else begin
                        row_n   = lowest_zero(rs);
                        cnt_n   = 4'd1;
                        state_n = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (!rs[row]) begin
                        cnt_n = cnt + 4'd1;
                        if (cnt_n == DB_TICKS) begin
                            state_n = PRESSED;
                            cnt_n   = 4'd0;
                            code_n  = {row, col};
                            valid_n = 1'b1;
                            held_n  = 1'b1;
                        end
                    end else begin
                        state_n = SCAN;
                        cnt_n   = 4'd0;
                        col_n   = col + 2'd1;
                    end
                end
                PRESSED: begin
                    // Only the captured row is watched; other keys cannot roll over.
                    if (rs[row]) begin
                        state_n = RELEASE;
                        cnt_n   = 4'd1;
                    end
                end
                RELEASE: begin
                    if (rs[row]) begin
                        cnt_n = cnt + 4'd1;
                        if (cnt_n == DB_TICKS) begin
                            state_n = SCAN;
                            held_n  = 1'b0;
                            cnt_n   = 4'd0;
                            col_n   = col + 2'd1;
                        end
                    end else begin
                        state_n = PRESSED;
                        cnt_n   = 4'd0;
                    end
                end
                default: begin
                    state_n = SCAN;
                    cnt_n   = 4'd0;
                end
            endcase
        end
    end

    a_cols_one_cold: assert property (@(posedge clk) disable iff (Reset) $onehot(~cols));
    a_valid_held:    assert property (@(posedge clk) disable iff (Reset) key_valid |-> key_held);

endmodule

// File: tb/tb_keypad_scan4.sv
// Bench for keypad_scan4: directed keypad scenarios, with confirmed presses
// tracked by an expected-code queue that the key_valid monitor drains.
module tb_keypad_scan4;

    logic       clk;
    logic       Reset;
    logic       tick;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] exp_q[$];
    logic [3:0] sb_exp;
    logic [3:0] seq[5];

    keypad_scan4 #(.DEBOUNCE_TICKS(4)) dut (
        .clk(clk),
        .Reset(Reset),
        .tick(tick),
        .rows(rows),
        .cols(cols),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_held(key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    endtask

    task automatic set_rows(input logic [3:0] v);
        rows = v;
        idle(3);
    endtask

    // Every key_valid pulse must match the oldest outstanding expected press.
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", 32'd1, 32'd0);
            end else begin
                sb_exp = exp_q.pop_front();
                chk("sb_key_code", 32'(key_code), 32'(sb_exp));
                chk("held_with_valid", 32'(key_held), 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1;
        tick  = 1'b0;
        rows  = 4'hF;
        idle(3);
        chk("rst_cols", 32'(cols), 32'h0E);
        chk("rst_code", 32'(key_code), 32'h0);
        chk("rst_valid", 32'(key_valid), 32'h0);
        chk("rst_held", 32'(key_held), 32'h0);
        Reset = 1'b0;
        idle(2);

        // Idle scanning walks the one-cold column drive with wrap.
        seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};
        for (int i = 0; i < 5; i++) begin
            ticks(1);
            chk("scan_cols", 32'(cols), 32'(seq[i]));
        end

        // Row 2 pressed at column 1 -> code 9.
        exp_q.push_back(4'd9);
        set_rows(4'b1011);
        ticks(3);
        chk("pre_confirm_held", 32'(key_held), 32'h0);
        ticks(1);
        chk("press_held", 32'(key_held), 32'h1);
        chk("press_cols", 32'(cols), 32'h0D);
        idle(1);
        chk("valid_one_clk", 32'(key_valid), 32'h0);
        chk("press_code", 32'(key_code), 32'h9);

        // Short release glitch must not re-trigger or drop the hold.
        set_rows(4'hF);
        ticks(2);
        set_rows(4'b1011);
        ticks(1);
        chk("glitch_held", 32'(key_held), 32'h1);
        set_rows(4'hF);
        ticks(3);
        chk("rel_pending_held", 32'(key_held), 32'h1);
        ticks(1);
        chk("rel_held", 32'(key_held), 32'h0);
        chk("rel_code_kept", 32'(key_code), 32'h9);
        chk("rel_cols_adv", 32'(cols), 32'h0B);

        // Bounce during column 1: aborted debounce resumes scanning.
        ticks(3);
        chk("back_to_col1", 32'(cols), 32'h0D);
        set_rows(4'b1011);
        ticks(2);
        set_rows(4'hF);
        ticks(1);
        chk("bounce_cols", 32'(cols), 32'h0B);
        chk("bounce_held", 32'(key_held), 32'h0);

        // Rows 0 and 2 low at column 3: row 0 wins -> code 3.
        ticks(1);
        chk("col3_cols", 32'(cols), 32'h07);
        exp_q.push_back(4'd3);
        set_rows(4'b1010);
        ticks(4);
        chk("prio_code", 32'(key_code), 32'h3);
        chk("prio_cols", 32'(cols), 32'h07);

        // Extra keys while held are ignored.
        set_rows(4'b0000);
        ticks(5);
        chk("rollover_code", 32'(key_code), 32'h3);
        chk("rollover_held", 32'(key_held), 32'h1);

        // Reset beats tick while pressed.
        @(negedge clk);
        Reset = 1'b1;
        tick  = 1'b1;
        rows  = 4'hF;
        @(negedge clk);
        Reset = 1'b0;
        tick  = 1'b0;
        chk("rst_pressed_cols", 32'(cols), 32'h0E);
        chk("rst_pressed_held", 32'(key_held), 32'h0);
        chk("rst_pressed_code", 32'(key_code), 32'h0);
        chk("rst_pressed_valid", 32'(key_valid), 32'h0);
        idle(2);
        ticks(1);
        chk("resume_cols", 32'(cols), 32'h0D);

        // Reset in the middle of a debounce discards the pending press.
        set_rows(4'b0111);
        ticks(1);
        @(negedge clk);
        Reset = 1'b1;
        rows  = 4'hF;
        @(negedge clk);
        Reset = 1'b0;
        chk("rst_deb_cols", 32'(cols), 32'h0E);
        idle(2);
        ticks(2);
        chk("rst_deb_scan", 32'(cols), 32'h0B);
        chk("rst_deb_held", 32'(key_held), 32'h0);

        idle(4);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
